// File: rtl/udp_tx_arbiter.sv
// Two-channel round-robin front end for a UDP sender: validates each packet's byte count,
// latches the winner's descriptor, relays its payload words and enforces an inter-frame gap.
module udp_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_BYTES  = 1472
) (
  input  logic        eth_txc,
  input  logic        rst_n,
  input  logic        ch0_req,
  input  logic [15:0] ch0_byte_num,
  input  logic [47:0] ch0_dest_mac,
  input  logic [31:0] ch0_dest_ip,
  input  logic [15:0] ch0_dest_port,
  input  logic [31:0] ch0_data,
  output logic        ch0_grant,
  output logic        ch0_data_req,
  output logic        ch0_done,
  output logic        ch0_drop,
  input  logic        ch1_req,
  input  logic [15:0] ch1_byte_num,
  input  logic [47:0] ch1_dest_mac,
  input  logic [31:0] ch1_dest_ip,
  input  logic [15:0] ch1_dest_port,
  input  logic [31:0] ch1_data,
  output logic        ch1_grant,
  output logic        ch1_data_req,
  output logic        ch1_done,
  output logic        ch1_drop,
  output logic        tx_start,
  output logic [31:0] tx_data,
  output logic [15:0] tx_byte_num,
  output logic [47:0] dest_mac_addr,
  output logic [31:0] dest_ip_addr,
  output logic [15:0] dest_udp_port,
  input  logic        tx_req,
  input  logic        tx_pkg_done
);

  localparam logic [15:0] MAX_BYTES_W = 16'(MAX_BYTES);
  localparam int          GAP_W       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] IFG_LOAD = GAP_W'(IFG_CYCLES);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t           state_reg;
  logic             rr_ptr_reg;
  logic [1:0]       grant_reg;
  logic [1:0]       done_reg;
  logic [1:0]       drop_reg;
  logic             tx_start_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [15:0]      byte_num_reg;
  logic [47:0]      mac_reg;
  logic [31:0]      ip_reg;
  logic [15:0]      port_reg;

  logic [1:0]  avail;
  logic [1:0]  data_req_vec;
  logic        win_ch;
  logic        win_valid;
  logic [15:0] win_bytes;
  logic        win_legal;

  // A channel whose drop is pulsing this cycle is masked, so a requester that
  // reacts to the drop one edge late is not rejected twice.
  assign avail     = {ch1_req & ~drop_reg[1], ch0_req & ~drop_reg[0]};
  assign win_ch    = avail[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;
  assign win_valid = |avail;
  assign win_bytes = win_ch ? ch1_byte_num : ch0_byte_num;
  assign win_legal = (win_bytes != 16'd0) && (win_bytes <= MAX_BYTES_W);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      assign data_req_vec[gi] = tx_req & grant_reg[gi];
    end
  endgenerate

  assign ch0_grant     = grant_reg[0];
  assign ch1_grant     = grant_reg[1];
  assign ch0_data_req  = data_req_vec[0];
  assign ch1_data_req  = data_req_vec[1];
  assign ch0_done      = done_reg[0];
  assign ch1_done      = done_reg[1];
  assign ch0_drop      = drop_reg[0];
  assign ch1_drop      = drop_reg[1];
  assign tx_start      = tx_start_reg;
  assign tx_byte_num   = byte_num_reg;
  assign dest_mac_addr = mac_reg;
  assign dest_ip_addr  = ip_reg;
  assign dest_udp_port = port_reg;
  assign tx_data       = grant_reg[0] ? ch0_data :
                         grant_reg[1] ? ch1_data : 32'd0;

  always_ff @(posedge eth_txc or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= 1'b0;
      grant_reg    <= 2'b00;
      done_reg     <= 2'b00;
      drop_reg     <= 2'b00;
      tx_start_reg <= 1'b0;
      gap_cnt_reg  <= '0;
      byte_num_reg <= 16'd0;
      mac_reg      <= 48'd0;
      ip_reg       <= 32'd0;
      port_reg     <= 16'd0;
    end else begin
      tx_start_reg <= 1'b0;
      done_reg     <= 2'b00;
      drop_reg     <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            if (win_legal) begin
              byte_num_reg      <= win_bytes;
              mac_reg           <= win_ch ? ch1_dest_mac  : ch0_dest_mac;
              ip_reg            <= win_ch ? ch1_dest_ip   : ch0_dest_ip;
              port_reg          <= win_ch ? ch1_dest_port : ch0_dest_port;
              grant_reg[win_ch] <= 1'b1;
              state_reg         <= START;
            end else begin
              drop_reg[win_ch] <= 1'b1;
              rr_ptr_reg       <= ~win_ch;
            end
          end
        end
        START: begin
          tx_start_reg <= 1'b1;
          state_reg    <= BUSY;
        end
        BUSY: begin
          if (tx_pkg_done) begin
            done_reg    <= grant_reg;
            rr_ptr_reg  <= ~grant_reg[1];
            grant_reg   <= 2'b00;
            gap_cnt_reg <= IFG_LOAD;
            state_reg   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: byte-count table plus hand-written sequences for
// latency, round-robin spacing, descriptor hold, spurious strobes and mid-packet reset.
module tb_udp_tx_arbiter;
  localparam int IFG = 12;
  localparam int MAXB = 1472;

  logic        eth_txc, rst_n;
  logic        ch0_req, ch1_req;
  logic [15:0] ch0_byte_num, ch1_byte_num, ch0_dest_port, ch1_dest_port;
  logic [47:0] ch0_dest_mac, ch1_dest_mac;
  logic [31:0] ch0_dest_ip, ch1_dest_ip, ch0_data, ch1_data;
  logic        ch0_grant, ch0_data_req, ch0_done, ch0_drop;
  logic        ch1_grant, ch1_data_req, ch1_done, ch1_drop;
  logic        tx_start, tx_req, tx_pkg_done;
  logic [31:0] tx_data, dest_ip_addr;
  logic [15:0] tx_byte_num, dest_udp_port;
  logic [47:0] dest_mac_addr;

  int checks = 0;
  int failures = 0;

  udp_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_BYTES(MAXB)) dut (
    .eth_txc(eth_txc), .rst_n(rst_n),
    .ch0_req(ch0_req), .ch0_byte_num(ch0_byte_num), .ch0_dest_mac(ch0_dest_mac),
    .ch0_dest_ip(ch0_dest_ip), .ch0_dest_port(ch0_dest_port), .ch0_data(ch0_data),
    .ch0_grant(ch0_grant), .ch0_data_req(ch0_data_req), .ch0_done(ch0_done), .ch0_drop(ch0_drop),
    .ch1_req(ch1_req), .ch1_byte_num(ch1_byte_num), .ch1_dest_mac(ch1_dest_mac),
    .ch1_dest_ip(ch1_dest_ip), .ch1_dest_port(ch1_dest_port), .ch1_data(ch1_data),
    .ch1_grant(ch1_grant), .ch1_data_req(ch1_data_req), .ch1_done(ch1_done), .ch1_drop(ch1_drop),
    .tx_start(tx_start), .tx_data(tx_data), .tx_byte_num(tx_byte_num),
    .dest_mac_addr(dest_mac_addr), .dest_ip_addr(dest_ip_addr), .dest_udp_port(dest_udp_port),
    .tx_req(tx_req), .tx_pkg_done(tx_pkg_done)
  );

  initial eth_txc = 1'b0;
  always #5 eth_txc = ~eth_txc;

  typedef struct {
    int          ch;
    logic [15:0] byte_num;
    logic        exp_drop;
    logic        exp_grant;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge eth_txc);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic val, input logic [15:0] bn);
    if (ch == 0) begin
      ch0_req = val;
      ch0_byte_num = bn;
    end else begin
      ch1_req = val;
      ch1_byte_num = bn;
    end
  endtask

  task automatic pkg_done_pulse();
    tx_pkg_done = 1'b1;
    tick();
    tx_pkg_done = 1'b0;
  endtask

  task automatic wait_gap();
    repeat (IFG + 4) tick();
  endtask

  initial begin
    logic [1:0] exp_v;
    logic       done_seen;
    logic       found;
    int         n;

    vecs[0] = '{ch: 1, byte_num: 16'd0,     exp_drop: 1'b1, exp_grant: 1'b0};
    vecs[1] = '{ch: 1, byte_num: 16'd1473,  exp_drop: 1'b1, exp_grant: 1'b0};
    vecs[2] = '{ch: 0, byte_num: 16'd1472,  exp_drop: 1'b0, exp_grant: 1'b1};
    vecs[3] = '{ch: 1, byte_num: 16'd1,     exp_drop: 1'b0, exp_grant: 1'b1};
    vecs[4] = '{ch: 0, byte_num: 16'hFFFF,  exp_drop: 1'b1, exp_grant: 1'b0};

    rst_n = 1'b0;
    ch0_req = 0; ch1_req = 0; tx_req = 0; tx_pkg_done = 0;
    ch0_byte_num = 0; ch1_byte_num = 0; ch0_dest_port = 0; ch1_dest_port = 0;
    ch0_dest_mac = 0; ch1_dest_mac = 0; ch0_dest_ip = 0; ch1_dest_ip = 0;
    ch0_data = 32'hDEADBEEF; ch1_data = 32'hCAFEF00D;

    // reset state, even with tx_req and data driven
    tx_req = 1'b1;
    repeat (2) tick();
    check("rst tx_start", tx_start, 0);
    check("rst grants", {ch1_grant, ch0_grant}, 0);
    check("rst tx_data", tx_data, 0);
    check("rst data_req", {ch1_data_req, ch0_data_req}, 0);
    check("rst descriptors", {tx_byte_num, dest_udp_port}, 0);
    check("rst mac_ip", {dest_mac_addr[15:0], dest_ip_addr}, 0);
    tx_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // spurious strobes in IDLE
    tx_req = 1'b1;
    #1;
    check("idle data_req", {ch1_data_req, ch0_data_req}, 0);
    check("idle tx_data", tx_data, 0);
    pkg_done_pulse();
    tx_req = 1'b0;
    check("idle done", {ch1_done, ch0_done}, 0);
    check("idle grant", {ch1_grant, ch0_grant}, 0);
    tick();
    check("idle tx_start", tx_start, 0);

    // single ch0 packet, descriptor hold
    ch0_byte_num = 16'd8; ch0_dest_port = 16'h1F90;
    ch0_dest_mac = 48'h001122334455; ch0_dest_ip = 32'hC0A8010A;
    ch0_data = 32'h11223344;
    ch0_req = 1'b1;
    tick();
    check("lat1 grant", ch0_grant, 1);
    check("lat1 tx_start", tx_start, 0);
    tick();
    check("lat2 tx_start", tx_start, 1);
    check("pkt byte_num", tx_byte_num, 16'd8);
    check("pkt port", dest_udp_port, 16'h1F90);
    check("pkt ip", dest_ip_addr, 32'hC0A8010A);
    check("pkt mac", dest_mac_addr, 48'h001122334455);
    ch0_dest_ip = 32'hC0A80114; ch0_dest_port = 16'h0050; ch0_byte_num = 16'd99;
    tick();
    check("tx_start width", tx_start, 0);
    tx_req = 1'b1;
    #1;
    check("data_req 1", {ch1_data_req, ch0_data_req}, 2'b01);
    check("tx_data 1", tx_data, 32'h11223344);
    tick();
    ch0_data = 32'h55667788;
    #1;
    check("data_req 2", ch0_data_req, 1);
    check("tx_data 2", tx_data, 32'h55667788);
    tx_req = 1'b0;
    #1;
    check("data_req off", ch0_data_req, 0);
    tick();
    check("busy ip hold", dest_ip_addr, 32'hC0A8010A);
    pkg_done_pulse();
    check("ch0 done", {ch1_done, ch0_done}, 2'b01);
    check("ch0 grant off", ch0_grant, 0);
    check("hold after done", {dest_ip_addr, dest_udp_port, tx_byte_num}, {32'hC0A8010A, 16'h1F90, 16'd8});
    ch0_req = 1'b0;
    tick();
    check("ch0 done width", ch0_done, 0);
    wait_gap();

    // byte-count table
    for (int i = 0; i < 5; i++) begin
      set_req(vecs[i].ch, 1'b1, vecs[i].byte_num);
      tick();
      exp_v = (vecs[i].ch == 0) ? {1'b0, vecs[i].exp_drop} : {vecs[i].exp_drop, 1'b0};
      check($sformatf("vec%0d drop", i), {ch1_drop, ch0_drop}, exp_v);
      exp_v = (vecs[i].ch == 0) ? {1'b0, vecs[i].exp_grant} : {vecs[i].exp_grant, 1'b0};
      check($sformatf("vec%0d grant", i), {ch1_grant, ch0_grant}, exp_v);
      if (vecs[i].exp_grant) begin
        tick();
        check($sformatf("vec%0d start", i), {tx_start, tx_byte_num}, {1'b1, vecs[i].byte_num});
        pkg_done_pulse();
        exp_v = (vecs[i].ch == 0) ? 2'b01 : 2'b10;
        check($sformatf("vec%0d done", i), {ch1_done, ch0_done}, exp_v);
        set_req(vecs[i].ch, 1'b0, vecs[i].byte_num);
        wait_gap();
      end else begin
        set_req(vecs[i].ch, 1'b0, vecs[i].byte_num);
        tick();
        check($sformatf("vec%0d idle", i), {tx_start, ch1_drop, ch0_drop, ch1_grant, ch0_grant}, 0);
      end
    end

    // simultaneous requests after reset: ch0, ch1, then ch0
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    ch0_byte_num = 16'd100; ch1_byte_num = 16'd200; ch1_dest_port = 16'h2222;
    ch0_req = 1'b1; ch1_req = 1'b1;
    tick();
    check("rr1 grant", {ch1_grant, ch0_grant}, 2'b01);
    tick();
    check("rr1 start", {tx_start, tx_byte_num}, {1'b1, 16'd100});
    pkg_done_pulse();
    check("rr1 done", {ch1_done, ch0_done}, 2'b01);
    ch0_req = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (tx_start) found = 1'b1;
    end
    check("rr2 start seen", found, 1);
    check("rr2 ifg spacing", 64'(n >= IFG + 2), 1);
    check("rr2 grant", {ch1_grant, ch0_grant}, 2'b10);
    check("rr2 desc", {tx_byte_num, dest_udp_port}, {16'd200, 16'h2222});
    pkg_done_pulse();
    check("rr2 done", {ch1_done, ch0_done}, 2'b10);
    ch1_req = 1'b0;
    wait_gap();
    ch0_req = 1'b1; ch1_req = 1'b1;
    tick();
    check("rr3 grant", {ch1_grant, ch0_grant}, 2'b01);
    tick();
    pkg_done_pulse();
    check("rr3 done", {ch1_done, ch0_done}, 2'b01);
    ch0_req = 1'b0; ch1_req = 1'b0;
    wait_gap();

    // reset during ch1 BUSY
    ch1_byte_num = 16'd64; ch1_dest_port = 16'h3333;
    ch1_req = 1'b1;
    repeat (3) tick();
    check("pre-rst grant", ch1_grant, 1);
    rst_n = 1'b0;
    #1;
    check("async rst outs", {tx_start, ch1_grant, ch0_grant, tx_byte_num, dest_udp_port}, 0);
    check("async rst data", tx_data, 0);
    ch1_req = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      tick();
      done_seen = done_seen | ch1_done;
    end
    rst_n = 1'b1;
    tick();
    done_seen = done_seen | ch1_done;
    check("rst no done", done_seen, 0);
    ch1_req = 1'b1;
    tick();
    tick();
    check("post-rst start", {tx_start, ch1_grant}, 2'b11);
    ch1_req = 1'b0;
    tick();
    pkg_done_pulse();
    check("no-abort done", {ch1_done, ch0_done}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12: minimum idle eth_txc cycles between tx_pkg_done and the next tx_start.
REQ-002 SHALL have parameter MAX_BYTES, default 1472: largest legal UDP payload in bytes.
REQ-003 SHALL have port eth_txc, input, 1 bit: clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports ch0_req and ch1_req, input, 1 bit each: level request to send one packet; held until chN_done or chN_drop.
REQ-006 SHALL have ports chN_byte_num [15:0], chN_dest_mac [47:0], chN_dest_ip [31:0] and chN_dest_port [15:0], all inputs, one set per channel: packet descriptor, stable while chN_req is high.
REQ-007 SHALL have ports chN_data, input, 32 bits per channel: payload word, MSB byte sent first.
REQ-008 SHALL have ports chN_grant, chN_data_req, chN_done and chN_drop, outputs, 1 bit each per channel: ownership level, word-fetch strobe, packet-sent pulse, and rejected-request pulse.
REQ-009 SHALL have sender-side ports tx_start (out, 1), tx_data (out, 32), tx_byte_num (out, 16), dest_mac_addr (out, 48), dest_ip_addr (out, 32), dest_udp_port (out, 16), tx_req (in, 1) and tx_pkg_done (in, 1).

Function
REQ-010 SHALL implement states IDLE, START, BUSY and GAP.
REQ-011 IDLE SHALL evaluate requests every cycle, with round-robin priority: the pointer favours the channel not served last, and the pointer after reset favours ch0.
REQ-012 On the winning request in IDLE, the block SHALL check the byte count: if chN_byte_num is 0 or greater than MAX_BYTES, it SHALL pulse chN_drop for 1 cycle, update the pointer, and stay in IDLE.
REQ-013 On a legal winning request, the block SHALL latch the channel's descriptor into the tx_byte_num, dest_* registers, assert chN_grant, and go to START.
REQ-014 START SHALL assert tx_start for exactly 1 cycle and then go to BUSY; total latency from request to tx_start SHALL be 2 cycles.
REQ-015 Latched descriptor outputs SHALL stay constant from START until the next grant, regardless of chN input changes.
REQ-016 tx_data SHALL be a combinational mux selecting chN_data of the granted channel, and SHALL be 0 when no channel is granted.
REQ-017 chN_data_req SHALL equal tx_req gated by chN_grant (combinational, zero latency); tx_req while nothing is granted SHALL be ignored.
REQ-018 In BUSY, tx_pkg_done SHALL deassert chN_grant, pulse chN_done for 1 cycle (registered, the cycle after tx_pkg_done), flip the pointer, load the gap counter, and go to GAP.
REQ-019 GAP SHALL count IFG_CYCLES cycles and then go to IDLE; requests arriving during GAP SHALL wait, and IFG_CYCLES=0 SHALL return to IDLE on the next cycle.
REQ-020 If both requests are active in IDLE, the pointer channel SHALL win; the loser SHALL be served next provided it is still requesting after GAP.
REQ-021 A chN_req deassertion during START or BUSY SHALL NOT abort the packet; completion SHALL still signal chN_done.
REQ-022 tx_pkg_done outside BUSY SHALL be ignored.
REQ-023 At most one chN_grant SHALL be high at any time; chN_done and chN_drop SHALL never both pulse in the same cycle.

Reset
REQ-024 While rst_n is low, the block SHALL go to IDLE, set the pointer to ch0, clear the gap counter, and drive all outputs to 0, including tx_start, grants, done/drop, descriptors and tx_data.
REQ-025 Reset asserted mid-packet SHALL drop the packet without a chN_done pulse; after release, the block SHALL restart arbitration from IDLE.

Verification
REQ-026 Single ch0 request, byte_num=8, dest_port=16'h1F90: tx_start 2 cycles after req; tx_byte_num=8, dest_udp_port=16'h1F90; ch0_data_req mirrors 2 tx_req strobes; ch0_done 1 cycle after tx_pkg_done.
REQ-027 ch0_req and ch1_req rising together after reset: ch0 is served first, then ch1 tx_start is at least IFG_CYCLES+2 cycles after ch0's tx_pkg_done; a third simultaneous round serves ch0 again.
REQ-028 ch1 request with byte_num=0, then byte_num=1473: ch1_drop pulses each time, tx_start never asserts, and the block stays in IDLE.
REQ-029 ch0 changes dest_ip from 192.168.1.10 to 192.168.1.20 during BUSY: dest_ip_addr stays 192.168.1.10 until the packet is done.
REQ-030 rst_n low for 3 cycles during BUSY of ch1: all outputs go to 0 immediately, with no ch1_done pulse; a subsequent ch1 request produces tx_start 2 cycles after it.
REQ-031 Spurious tx_req and tx_pkg_done pulses in IDLE: no chN_data_req, no chN_done, and no state change.
